// File: rtl/xlr8_tdet_pkg.sv
// rtl/xlr8_tdet_pkg.sv - shared types and constants for the tone-period detector XB
package xlr8_tdet_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } tdet_state_e;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_EDGE  = 1;
    localparam int CTRL_AVG   = 2;

    localparam int STAT_VALID = 0;
    localparam int STAT_TMO   = 1;
    localparam int STAT_OVR   = 2;

    localparam int              CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/xlr8_tdet_edge.sv
// rtl/xlr8_tdet_edge.sv - tone input synchroniser and selectable single-cycle edge detector
module xlr8_tdet_edge (
    input  logic clk,
    input  logic rst,
    input  logic clken,
    input  logic pin,
    input  logic edge_sel,
    output logic edge_pulse
);

    logic sync1;
    logic sync2;
    logic dly;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            dly   <= 1'b0;
        end else if (clken) begin
            sync1 <= pin;
            sync2 <= sync1;
            dly   <= sync2;
        end
    end

    // edge_sel = 1 selects falling edges
    assign edge_pulse = clken && (edge_sel ? (dly && !sync2) : (sync2 && !dly));

endmodule

// File: rtl/xlr8_tone_detect.sv
// rtl/xlr8_tone_detect.sv - tone period detector XB; averaging enabled by XLR8_TDET_AVG_EN
import xlr8_tdet_pkg::*;

module xlr8_tone_detect #(
    parameter logic [7:0] TDET_CTRL_ADDR = 8'h00,
    parameter logic [7:0] TDET_STAT_ADDR = 8'h00,
    parameter logic [7:0] TDET_PERL_ADDR = 8'h00,
    parameter logic [7:0] TDET_PERH_ADDR = 8'h00,
    parameter int         PRESCALE       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clken,
    input  logic [7:0] dbus_in,
    output logic [7:0] dbus_out,
    output logic       io_out_en,
    input  logic [7:0] ramadr,
    input  logic       ramre,
    input  logic       ramwe,
    input  logic       dm_sel,
    input  logic       tone_in,
    output logic       tdet_valid
);

    localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    tdet_state_e      state, state_nxt;
    logic [7:0]       ctrl;
    logic             valid, tmo, ovr;
    logic [CNT_W-1:0] period;
    logic [7:0]       shadow;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic [PRE_W-1:0] pre;
    logic             edge_p, tick, restart, cap, tmo_set, publish, en;
    logic [CNT_W-1:0] pub_val;

    logic rd_ctrl, rd_stat, rd_perl, rd_perh, wr_ctrl, wr_stat;
    assign rd_ctrl = dm_sel && ramre && (ramadr == TDET_CTRL_ADDR);
    assign rd_stat = dm_sel && ramre && (ramadr == TDET_STAT_ADDR);
    assign rd_perl = dm_sel && ramre && (ramadr == TDET_PERL_ADDR);
    assign rd_perh = dm_sel && ramre && (ramadr == TDET_PERH_ADDR);
    assign wr_ctrl = dm_sel && ramwe && (ramadr == TDET_CTRL_ADDR);
    assign wr_stat = dm_sel && ramwe && (ramadr == TDET_STAT_ADDR);

    assign en = ctrl[CTRL_EN];

    xlr8_tdet_edge u_edge (
        .clk        (clk),
        .rst        (rst),
        .clken      (clken),
        .pin        (tone_in),
        .edge_sel   (ctrl[CTRL_EDGE]),
        .edge_pulse (edge_p)
    );

    assign tick = (state == ST_MEASURE) && (pre == PRE_LAST);
    // The tick landing on the capture cycle belongs to the period being closed
    assign cnt_inc = (tick && (cnt != CNT_MAX)) ? cnt + 1'b1 : cnt;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else if (clken) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        cap       = 1'b0;
        tmo_set   = 1'b0;
        if (!en) begin
            state_nxt = ST_IDLE;
            restart   = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_ARM;
                    restart   = 1'b1;
                end
                ST_ARM: begin
                    if (edge_p) begin
                        state_nxt = ST_MEASURE;
                        restart   = 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (edge_p) begin
                        cap     = 1'b1;
                        restart = 1'b1;
                    end else if (tick && (cnt == CNT_MAX)) begin
                        tmo_set   = 1'b1;
                        restart   = 1'b1;
                        state_nxt = ST_ARM;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            pre <= '0;
        end else if (clken) begin
            if (restart) begin
                cnt <= '0;
                pre <= '0;
            end else if (state == ST_MEASURE) begin
                cnt <= cnt_inc;
                pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
            end
        end
    end

`ifdef XLR8_TDET_AVG_EN
    logic        avg_on;
    logic [17:0] acc, acc_sum;
    logic [1:0]  nsamp;

    assign avg_on  = ctrl[CTRL_AVG];
    assign acc_sum = acc + {2'b00, cnt_inc};
    assign publish = cap && (!avg_on || (nsamp == 2'd3));
    assign pub_val = avg_on ? acc_sum[17:2] : cnt_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            nsamp <= '0;
        end else if (clken) begin
            if (tmo_set || !en || (cap && avg_on && (nsamp == 2'd3))) begin
                acc   <= '0;
                nsamp <= '0;
            end else if (cap && avg_on) begin
                acc   <= acc_sum;
                nsamp <= nsamp + 2'd1;
            end
        end
    end
`else
    assign publish = cap;
    assign pub_val = cnt_inc;
`endif

    // A capture beats a coincident PERH read (VALID stays, no OVR) and beats W1C
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl   <= '0;
            valid  <= 1'b0;
            tmo    <= 1'b0;
            ovr    <= 1'b0;
            period <= '0;
            shadow <= '0;
        end else if (clken) begin
            if (wr_ctrl) ctrl <= dbus_in;
            if (publish) period <= pub_val;
            if (rd_perl) shadow <= period[15:8];

            if (publish) valid <= 1'b1;
            else if (rd_perh) valid <= 1'b0;

            if (publish && valid && !rd_perh) ovr <= 1'b1;
            else if (wr_stat && dbus_in[STAT_OVR]) ovr <= 1'b0;

            if (tmo_set) tmo <= 1'b1;
            else if (wr_stat && dbus_in[STAT_TMO]) tmo <= 1'b0;
        end
    end

    always_comb begin
        dbus_out  = '0;
        io_out_en = 1'b0;
        if (!rst) begin
            io_out_en = rd_ctrl || rd_stat || rd_perl || rd_perh;
            if (rd_ctrl)      dbus_out = ctrl;
            else if (rd_stat) dbus_out = {5'b0, ovr, tmo, valid};
            else if (rd_perl) dbus_out = period[7:0];
            else if (rd_perh) dbus_out = shadow;
        end
    end

    assign tdet_valid = valid;

endmodule

// File: tb/tb_xlr8_tone_detect.sv
// tb/tb_xlr8_tone_detect.sv - directed self-checking bench for xlr8_tone_detect (PRESCALE 1 and 4)
module tb_xlr8_tone_detect;

    localparam logic [7:0] A_CTRL = 8'h60;
    localparam logic [7:0] A_STAT = 8'h61;
    localparam logic [7:0] A_PERL = 8'h62;
    localparam logic [7:0] A_PERH = 8'h63;

    logic       clk = 1'b0;
    logic       rst, clken, ramre, ramwe, dm_sel, tone_in;
    logic [7:0] dbus_in, ramadr;
    logic [7:0] dbus_out, dbus_out4;
    logic       io_out_en, io_out_en4, tdet_valid, tdet_valid4;

    int errors = 0;
    int checks = 0;
    logic [7:0] d1, d4;
    logic       oe;

    always #5 clk = ~clk;

    xlr8_tone_detect #(
        .TDET_CTRL_ADDR(A_CTRL), .TDET_STAT_ADDR(A_STAT),
        .TDET_PERL_ADDR(A_PERL), .TDET_PERH_ADDR(A_PERH), .PRESCALE(1)
    ) u_dut (
        .clk(clk), .rst(rst), .clken(clken), .dbus_in(dbus_in), .dbus_out(dbus_out),
        .io_out_en(io_out_en), .ramadr(ramadr), .ramre(ramre), .ramwe(ramwe),
        .dm_sel(dm_sel), .tone_in(tone_in), .tdet_valid(tdet_valid)
    );

    xlr8_tone_detect #(
        .TDET_CTRL_ADDR(A_CTRL), .TDET_STAT_ADDR(A_STAT),
        .TDET_PERL_ADDR(A_PERL), .TDET_PERH_ADDR(A_PERH), .PRESCALE(4)
    ) u_dut4 (
        .clk(clk), .rst(rst), .clken(clken), .dbus_in(dbus_in), .dbus_out(dbus_out4),
        .io_out_en(io_out_en4), .ramadr(ramadr), .ramre(ramre), .ramwe(ramwe),
        .dm_sel(dm_sel), .tone_in(tone_in), .tdet_valid(tdet_valid4)
    );

    // All tasks start and end on a falling clock edge
    task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
        dm_sel = 1'b1; ramwe = 1'b1; ramadr = addr; dbus_in = data;
        @(negedge clk);
        dm_sel = 1'b0; ramwe = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] addr, output logic [7:0] r1,
                            output logic [7:0] r4, output logic roe);
        dm_sel = 1'b1; ramre = 1'b1; ramadr = addr;
        #1;
        r1 = dbus_out; r4 = dbus_out4; roe = io_out_en;
        @(negedge clk);
        dm_sel = 1'b0; ramre = 1'b0;
    endtask

    task automatic square(input int period, input int high, input int nper);
        for (int i = 0; i < nper; i++) begin
            tone_in = 1'b1;
            repeat (high) @(negedge clk);
            tone_in = 1'b0;
            repeat (period - high) @(negedge clk);
        end
    endtask

    task automatic do_reset;
        tone_in = 1'b0; clken = 1'b1; dm_sel = 1'b0; ramre = 1'b0; ramwe = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (io_out_en !== 1'b0) begin errors++; $display("FAIL rst_oe_idle: got %b want 0", io_out_en); end
        checks++; if (tdet_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", tdet_valid); end
        bus_read(A_CTRL, d1, d4, oe);
        checks++; if (d1 !== 8'h00) begin errors++; $display("FAIL rst_ctrl: got %h want 00", d1); end
        checks++; if (oe !== 1'b1) begin errors++; $display("FAIL rst_oe_read: got %b want 1", oe); end
        bus_read(A_STAT, d1, d4, oe);
        checks++; if (d1 !== 8'h00) begin errors++; $display("FAIL rst_stat: got %h want 00", d1); end
        bus_read(A_PERL, d1, d4, oe);
        checks++; if (d1 !== 8'h00) begin errors++; $display("FAIL rst_perl: got %h want 00", d1); end
        bus_read(A_PERH, d1, d4, oe);
        checks++; if (d1 !== 8'h00) begin errors++; $display("FAIL rst_perh: got %h want 00", d1); end
    endtask

    task automatic test_rising_400;
        do_reset;
        bus_write(A_CTRL, 8'h01);
        square(400, 200, 1);
        checks++; if (tdet_valid !== 1'b0) begin errors++; $display("FAIL r400_valid_early: got %b want 0", tdet_valid); end
        square(400, 200, 1);
        checks++; if (tdet_valid !== 1'b1) begin errors++; $display("FAIL r400_valid: got %b want 1", tdet_valid); end
        checks++; if (tdet_valid4 !== 1'b1) begin errors++; $display("FAIL r400_valid4: got %b want 1", tdet_valid4); end
        bus_read(A_PERL, d1, d4, oe);
        checks++; if (d1 !== 8'h90) begin errors++; $display("FAIL r400_perl: got %h want 90", d1); end
        checks++; if (d4 !== 8'h64) begin errors++; $display("FAIL r400_perl_ps4: got %h want 64", d4); end
        bus_read(A_PERH, d1, d4, oe);
        checks++; if (d1 !== 8'h01) begin errors++; $display("FAIL r400_perh: got %h want 01", d1); end
        checks++; if (d4 !== 8'h00) begin errors++; $display("FAIL r400_perh_ps4: got %h want 00", d4); end
        checks++; if (tdet_valid !== 1'b0) begin errors++; $display("FAIL r400_valid_clr: got %b want 0", tdet_valid); end
        checks++; if (tdet_valid4 !== 1'b0) begin errors++; $display("FAIL r400_valid_clr4: got %b want 0", tdet_valid4); end
    endtask

    task automatic test_falling_1000;
        do_reset;
        bus_write(A_CTRL, 8'h03);
        square(1000, 300, 2);
        bus_read(A_PERL, d1, d4, oe);
        checks++; if (d1 !== 8'hE8) begin errors++; $display("FAIL f1000_perl: got %h want e8", d1); end
        checks++; if (d4 !== 8'hFA) begin errors++; $display("FAIL f1000_perl_ps4: got %h want fa", d4); end
        bus_read(A_PERH, d1, d4, oe);
        checks++; if (d1 !== 8'h03) begin errors++; $display("FAIL f1000_perh: got %h want 03", d1); end
    endtask

    task automatic test_timeout;
        do_reset;
        bus_write(A_CTRL, 8'h01);
        square(20, 10, 2);
        repeat (65516) @(negedge clk);
        bus_read(A_STAT, d1, d4, oe);
        checks++; if (d1 !== 8'h01) begin errors++; $display("FAIL tmo_before: got %h want 01", d1); end
        repeat (4) @(negedge clk);
        bus_read(A_STAT, d1, d4, oe);
        checks++; if (d1 !== 8'h03) begin errors++; $display("FAIL tmo_set: got %h want 03", d1); end
        bus_read(A_PERL, d1, d4, oe);
        checks++; if (d1 !== 8'h14) begin errors++; $display("FAIL tmo_perl_kept: got %h want 14", d1); end
        bus_read(A_PERH, d1, d4, oe);
        bus_write(A_STAT, 8'h02);
        bus_read(A_STAT, d1, d4, oe);
        checks++; if (d1 !== 8'h00) begin errors++; $display("FAIL tmo_w1c: got %h want 00", d1); end
        tone_in = 1'b1; repeat (15) @(negedge clk);
        tone_in = 1'b0; repeat (15) @(negedge clk);
        bus_read(A_STAT, d1, d4, oe);
        checks++; if (d1 !== 8'h00) begin errors++; $display("FAIL tmo_rearm: got %h want 00", d1); end
        tone_in = 1'b1; repeat (5) @(negedge clk);
        checks++; if (tdet_valid !== 1'b1) begin errors++; $display("FAIL tmo_recap_valid: got %b want 1", tdet_valid); end
        bus_read(A_PERL, d1, d4, oe);
        checks++; if (d1 !== 8'h1F) begin errors++; $display("FAIL tmo_recap_perl: got %h want 1f", d1); end
    endtask

    task automatic test_overrun;
        do_reset;
        bus_write(A_CTRL, 8'h01);
        square(200, 100, 2);
        square(150, 75, 2);
        bus_read(A_STAT, d1, d4, oe);
        checks++; if (d1 !== 8'h05) begin errors++; $display("FAIL ovr_stat: got %h want 05", d1); end
        bus_read(A_PERL, d1, d4, oe);
        checks++; if (d1 !== 8'h96) begin errors++; $display("FAIL ovr_perl: got %h want 96", d1); end
        bus_read(A_PERH, d1, d4, oe);
        checks++; if (d1 !== 8'h00) begin errors++; $display("FAIL ovr_perh: got %h want 00", d1); end
        bus_write(A_STAT, 8'h04);
        bus_read(A_STAT, d1, d4, oe);
        checks++; if (d1 !== 8'h00) begin errors++; $display("FAIL ovr_w1c: got %h want 00", d1); end
        // capture on the same cycle as the PERH read
        tone_in = 1'b1; repeat (20) @(negedge clk);
        tone_in = 1'b0; repeat (20) @(negedge clk);
        bus_read(A_PERL, d1, d4, oe);
        tone_in = 1'b1; repeat (2) @(negedge clk);
        bus_read(A_PERH, d1, d4, oe);
        bus_read(A_STAT, d1, d4, oe);
        checks++; if (d1 !== 8'h01) begin errors++; $display("FAIL ovr_cap_vs_perh: got %h want 01", d1); end
        // capture on the same cycle as an OVR W1C
        tone_in = 1'b0; repeat (20) @(negedge clk);
        tone_in = 1'b1; repeat (2) @(negedge clk);
        bus_write(A_STAT, 8'h04);
        bus_read(A_STAT, d1, d4, oe);
        checks++; if (d1 !== 8'h05) begin errors++; $display("FAIL ovr_set_vs_w1c: got %h want 05", d1); end
    endtask

    task automatic test_atomic_read;
        do_reset;
        bus_write(A_CTRL, 8'h01);
        square(308, 154, 2);
        bus_read(A_PERL, d1, d4, oe);
        checks++; if (d1 !== 8'h34) begin errors++; $display("FAIL atom_perl: got %h want 34", d1); end
        checks++; if (oe !== 1'b1) begin errors++; $display("FAIL atom_oe_read: got %b want 1", oe); end
        repeat (323) @(negedge clk);
        tone_in = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        checks++; if (io_out_en !== 1'b0) begin errors++; $display("FAIL atom_oe_idle: got %b want 0", io_out_en); end
        @(negedge clk);
        bus_read(A_PERH, d1, d4, oe);
        checks++; if (d1 !== 8'h01) begin errors++; $display("FAIL atom_perh_shadow: got %h want 01", d1); end
        bus_read(A_PERL, d1, d4, oe);
        checks++; if (d1 !== 8'h78) begin errors++; $display("FAIL atom_perl_new: got %h want 78", d1); end
        bus_read(A_PERH, d1, d4, oe);
        checks++; if (d1 !== 8'h02) begin errors++; $display("FAIL atom_perh_new: got %h want 02", d1); end
    endtask

    task automatic test_reset_in_measure;
        do_reset;
        bus_write(A_CTRL, 8'hA1);
        square(50, 25, 2);
        bus_read(A_CTRL, d1, d4, oe);
        checks++; if (d1 !== 8'hA1) begin errors++; $display("FAIL rm_ctrl: got %h want a1", d1); end
        clken = 1'b0;
        bus_write(A_CTRL, 8'h00);
        clken = 1'b1;
        bus_read(A_CTRL, d1, d4, oe);
        checks++; if (d1 !== 8'hA1) begin errors++; $display("FAIL rm_clken_hold: got %h want a1", d1); end
        rst = 1'b1;
        bus_read(A_CTRL, d1, d4, oe);
        checks++; if (d1 !== 8'h00) begin errors++; $display("FAIL rm_dbus_in_rst: got %h want 00", d1); end
        checks++; if (oe !== 1'b0) begin errors++; $display("FAIL rm_oe_in_rst: got %b want 0", oe); end
        rst = 1'b0;
        bus_read(A_CTRL, d1, d4, oe);
        checks++; if (d1 !== 8'h00) begin errors++; $display("FAIL rm_ctrl_after: got %h want 00", d1); end
        bus_read(A_STAT, d1, d4, oe);
        checks++; if (d1 !== 8'h00) begin errors++; $display("FAIL rm_stat_after: got %h want 00", d1); end
        bus_read(A_PERL, d1, d4, oe);
        checks++; if (d1 !== 8'h00) begin errors++; $display("FAIL rm_perl_after: got %h want 00", d1); end
        checks++; if (tdet_valid !== 1'b0) begin errors++; $display("FAIL rm_valid_after: got %b want 0", tdet_valid); end
    endtask

`ifdef XLR8_TDET_AVG_EN
    task automatic test_average;
        do_reset;
        bus_write(A_CTRL, 8'h05);
        square(100, 50, 1);
        square(102, 51, 1);
        square(98, 49, 1);
        square(100, 50, 1);
        checks++; if (tdet_valid !== 1'b0) begin errors++; $display("FAIL avg_valid_early: got %b want 0", tdet_valid); end
        tone_in = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (tdet_valid !== 1'b1) begin errors++; $display("FAIL avg_valid: got %b want 1", tdet_valid); end
        bus_read(A_PERL, d1, d4, oe);
        checks++; if (d1 !== 8'h64) begin errors++; $display("FAIL avg_perl: got %h want 64", d1); end
    endtask
`endif

    initial begin
        rst = 1'b1; clken = 1'b1; tone_in = 1'b0; dm_sel = 1'b0;
        ramre = 1'b0; ramwe = 1'b0; ramadr = 8'h00; dbus_in = 8'h00;
        @(negedge clk);
        test_reset;
        test_rising_400;
        test_falling_1000;
        test_overrun;
        test_atomic_read;
        test_reset_in_measure;
`ifdef XLR8_TDET_AVG_EN
        test_average;
`endif
        test_timeout;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
